// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared opcodes, FSM state type and default watchdog length for PC hazard control
package pc_ctrl_pkg;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int TIMEOUT_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, WAIT, REDIRECT} state_t;
endpackage

// File: rtl/pc_hazard_ctrl_cf_decode.sv
// cf_decode: flags a valid control-flow opcode (JAL/JALR/BRANCH) in decode; ports id_valid, id_op7 -> cf_hit
module cf_decode
  import pc_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] id_op7,
  output logic       cf_hit
);
  assign cf_hit = id_valid & (id_op7 == OP_JAL || id_op7 == OP_JALR || id_op7 == OP_BRANCH);
endmodule

// File: rtl/pc_hazard_ctrl.sv
// pc_hazard_ctrl: stalls fetch on decoded control flow until execute resolves, redirects on taken; ports clk, rst_n, id_*, ex_* in; halt_pc, pc_sel, flush_if, npc, busy, err_timeout, stall_cnt, taken_cnt out; BRANCH_STATS_EN enables the statistics counters
module pc_hazard_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_op7,
  input  logic              ex_resolve,
  input  logic              ex_taken,
  input  logic [XLEN-1:0]   ex_target,
  output logic              halt_pc,
  output logic              pc_sel,
  output logic              flush_if,
  output logic [XLEN-1:0]   npc,
  output logic              busy,
  output logic              err_timeout,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] taken_cnt
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [XLEN-1:0] r_npc;
  logic            r_err;
  logic            w_cf_hit;
  logic            w_taken;
  cf_decode u_cf_decode (
    .id_valid (id_valid),
    .id_op7   (id_op7),
    .cf_hit   (w_cf_hit)
  );
  // halt is combinational so the PC freezes in the same cycle the branch is decoded
  assign halt_pc     = (r_state == WAIT) | ((r_state == IDLE) & w_cf_hit);
  assign pc_sel      = r_state == REDIRECT;
  assign flush_if    = r_state == REDIRECT;
  assign busy        = r_state != IDLE;
  assign npc         = r_npc;
  assign err_timeout = r_err;
  assign w_taken     = (r_state == WAIT) & ex_resolve & ex_taken;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_npc   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_cf_hit) r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= r_timer + 1'b1;
          // a resolve arriving on the expiry cycle wins over the watchdog
          if (ex_resolve) begin
            r_state <= ex_taken ? REDIRECT : IDLE;
            if (ex_taken) r_npc <= ex_target;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt;
  logic [STAT_W-1:0] r_taken_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (halt_pc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_taken && r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign taken_cnt = r_taken_cnt;
`else
  assign stall_cnt = '0;
  assign taken_cnt = '0;
`endif
endmodule
